// File: rtl/mips_boot_loader.sv
// Boot/preload engine for MIPS_core: holds the core in reset, optionally zero-fills memories,
// loads header+payload records from a 32-bit word stream and releases the core on an END record.
module mips_boot_loader #(
    parameter int DATA_W        = 32,
    parameter int IMEM_DEPTH    = 512,
    parameter int DMEM_DEPTH    = 1024,
    parameter int RF_DEPTH      = 32,
    parameter int ADDR_W        = 16,
    parameter int CLEAR_ON_BOOT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic              dmem_we,
    output logic              rf_we,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              core_rst,
    output logic              boot_done,
    output logic              err
);

    localparam int CW    = ADDR_W + 1;
    localparam int MAX_D = (IMEM_DEPTH > DMEM_DEPTH)
                         ? ((IMEM_DEPTH > RF_DEPTH) ? IMEM_DEPTH : RF_DEPTH)
                         : ((DMEM_DEPTH > RF_DEPTH) ? DMEM_DEPTH : RF_DEPTH);
    localparam logic [CW-1:0] CLR_LAST = CW'(MAX_D - 1);
    localparam logic [CW-1:0] IMEM_LIM = CW'(IMEM_DEPTH);
    localparam logic [CW-1:0] DMEM_LIM = CW'(DMEM_DEPTH);
    localparam logic [CW-1:0] RF_LIM   = CW'(RF_DEPTH);

    typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_LOAD, S_RUN, S_ERR} state_t;
    localparam state_t BOOT_STATE = (CLEAR_ON_BOOT != 0) ? S_CLEAR : S_IDLE;

    state_t              state_q, state_d;
    logic [CW-1:0]       clr_q, clr_d;
    logic [1:0]          tgt_q, tgt_d;
    logic [15:0]         base_q, base_d;
    logic [13:0]         cnt_q, cnt_d;
    logic [13:0]         k_q, k_d;
    logic                imem_we_q, imem_we_d, dmem_we_q, dmem_we_d, rf_we_q, rf_we_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                in_ready_q, in_ready_d;
    logic                core_rst_q, core_rst_d;
    logic                boot_done_q, boot_done_d;
    logic                err_q, err_d;

    logic                accept;
    logic [1:0]          hdr_tgt;
    logic [13:0]         hdr_cnt;
    logic [15:0]         hdr_base;
    logic [16:0]         hdr_end;
    logic [15:0]         ld_addr;

    function automatic logic [16:0] tgt_depth(input logic [1:0] t);
        case (t)
            2'b00:   return 17'(IMEM_DEPTH);
            2'b01:   return 17'(DMEM_DEPTH);
            default: return 17'(RF_DEPTH);
        endcase
    endfunction

    assign accept   = in_valid & in_ready_q;
    assign hdr_tgt  = in_data[31:30];
    assign hdr_cnt  = in_data[29:16];
    assign hdr_base = in_data[15:0];
    // Range check in 17 bits so base+count can never wrap past a small depth.
    assign hdr_end  = {1'b0, hdr_base} + {3'b000, hdr_cnt};
    assign ld_addr  = base_q + {2'b00, k_q};

    always_comb begin
        state_d     = state_q;
        clr_d       = clr_q;
        tgt_d       = tgt_q;
        base_d      = base_q;
        cnt_d       = cnt_q;
        k_d         = k_q;
        imem_we_d   = 1'b0;
        dmem_we_d   = 1'b0;
        rf_we_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        in_ready_d  = in_ready_q;
        core_rst_d  = core_rst_q;
        boot_done_d = boot_done_q;
        err_d       = err_q;

        case (state_q)
            S_CLEAR: begin
                wr_addr_d = clr_q[ADDR_W-1:0];
                wr_data_d = '0;
                imem_we_d = (clr_q < IMEM_LIM);
                dmem_we_d = (clr_q < DMEM_LIM);
                rf_we_d   = (clr_q < RF_LIM);
                if (clr_q == CLR_LAST) begin
                    clr_d      = '0;
                    state_d    = S_IDLE;
                    in_ready_d = 1'b1;
                end else begin
                    clr_d = clr_q + 1'b1;
                end
            end
            S_IDLE: begin
                in_ready_d = 1'b1;
                if (accept) begin
                    if (hdr_tgt == 2'b11) begin
                        state_d     = S_RUN;
                        in_ready_d  = 1'b0;
                        core_rst_d  = 1'b0;
                        boot_done_d = 1'b1;
                    end else if (hdr_cnt == 14'd0) begin
                        state_d = S_IDLE;
                    end else if (hdr_end > tgt_depth(hdr_tgt)) begin
                        state_d    = S_ERR;
                        err_d      = 1'b1;
                        in_ready_d = 1'b0;
                    end else begin
                        tgt_d   = hdr_tgt;
                        base_d  = hdr_base;
                        cnt_d   = hdr_cnt;
                        k_d     = '0;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                in_ready_d = 1'b1;
                if (accept) begin
                    wr_addr_d = ADDR_W'(ld_addr);
                    wr_data_d = in_data;
                    imem_we_d = (tgt_q == 2'b00);
                    dmem_we_d = (tgt_q == 2'b01);
                    // Register 0 is hardwired zero in the core; drop writes to it.
                    rf_we_d   = (tgt_q == 2'b10) && (ld_addr != 16'd0);
                    k_d       = k_q + 14'd1;
                    if ((k_q + 14'd1) == cnt_q) state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (reload) begin
                    state_d     = BOOT_STATE;
                    clr_d       = '0;
                    in_ready_d  = 1'b0;
                    core_rst_d  = 1'b1;
                    boot_done_d = 1'b0;
                end
            end
            S_ERR: begin
                in_ready_d = 1'b0;
                core_rst_d = 1'b1;
                err_d      = 1'b1;
            end
            default: state_d = S_ERR;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= BOOT_STATE;
            clr_q       <= '0;
            tgt_q       <= '0;
            base_q      <= '0;
            cnt_q       <= '0;
            k_q         <= '0;
            imem_we_q   <= 1'b0;
            dmem_we_q   <= 1'b0;
            rf_we_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            in_ready_q  <= 1'b0;
            core_rst_q  <= 1'b1;
            boot_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_q       <= clr_d;
            tgt_q       <= tgt_d;
            base_q      <= base_d;
            cnt_q       <= cnt_d;
            k_q         <= k_d;
            imem_we_q   <= imem_we_d;
            dmem_we_q   <= dmem_we_d;
            rf_we_q     <= rf_we_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            in_ready_q  <= in_ready_d;
            core_rst_q  <= core_rst_d;
            boot_done_q <= boot_done_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign imem_we   = imem_we_q;
    assign dmem_we   = dmem_we_q;
    assign rf_we     = rf_we_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign core_rst  = core_rst_q;
    assign boot_done = boot_done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mips_boot_loader.sv
// Scoreboard bench for mips_boot_loader: every expected write (with its cycle) is queued when
// the stimulus is driven and compared against the strobes seen on the falling edge.
module tb_mips_boot_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'h0;
    logic        reload = 1'b0;
    logic        in_ready, imem_we, dmem_we, rf_we, core_rst, boot_done, err;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;

    mips_boot_loader #(
        .DATA_W(32), .IMEM_DEPTH(512), .DMEM_DEPTH(64), .RF_DEPTH(32),
        .ADDR_W(16), .CLEAR_ON_BOOT(1)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .reload(reload), .imem_we(imem_we), .dmem_we(dmem_we), .rf_we(rf_we),
        .wr_addr(wr_addr), .wr_data(wr_data), .core_rst(core_rst),
        .boot_done(boot_done), .err(err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [31:0] stamp;
        logic [2:0]  mask;
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    task automatic chk_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_t got;
        if (imem_we | dmem_we | rf_we) begin
            got.stamp = cyc;
            got.mask  = {imem_we, dmem_we, rf_we};
            got.addr  = wr_addr;
            got.data  = wr_data;
            if (exp_q.size() == 0) chk_eq("spurious_wr", 128'(got), 128'(0));
            else                   chk_eq("wr", 128'(got), 128'(exp_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (!done) chk_eq("send_timeout", 128'(0), 128'(1));
    endtask

    task automatic push_wr(input logic [2:0] mask, input logic [15:0] addr, input logic [31:0] data);
        wr_t e;
        e.stamp = cyc;
        e.mask  = mask;
        e.addr  = addr;
        e.data  = data;
        exp_q.push_back(e);
    endtask

    // The first clear write is registered on the edge after the boot sequence begins.
    task automatic push_clear();
        wr_t e;
        for (int c = 0; c < 512; c++) begin
            e.stamp   = cyc + 1 + c;
            e.mask[2] = (c < 512);
            e.mask[1] = (c < 64);
            e.mask[0] = (c < 32);
            e.addr    = 16'(c);
            e.data    = 32'h0;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        chk_eq(tag, 128'(exp_q.size()), 128'(0));
        tick();
    endtask

    task automatic chk_reset_outs(input string tag);
        chk_eq(tag, 128'({imem_we, dmem_we, rf_we, wr_addr, wr_data, in_ready, core_rst, boot_done, err}),
               128'({3'b000, 16'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0}));
    endtask

    logic [31:0] prog [4] = '{32'h2001000f, 32'h20020002, 32'h00220018, 32'h03e10018};
    logic [31:0] dmw  [3] = '{32'hA5A5_0001, 32'h5A5A_0002, 32'h1234_5678};

    initial begin
        // Reset and first clear
        repeat (3) tick();
        chk_reset_outs("reset_state");
        rst = 1'b1;
        push_clear();
        tick();
        chk_eq("clear_ready", 128'({in_ready, core_rst, boot_done}), 128'(3'b010));
        wait_drain("clear1_drain");
        chk_eq("idle_ready", 128'(in_ready), 128'(1));

        // IMEM load at base 1
        send(32'h0004_0001);
        for (int i = 0; i < 4; i++) begin
            send(prog[i]);
            push_wr(3'b100, 16'(1 + i), prog[i]);
        end

        // RF load to r31, then END
        send(32'h8001_001F);
        send(32'h1001_0000);
        push_wr(3'b001, 16'd31, 32'h1001_0000);
        send(32'hC000_0000);
        chk_eq("run_entry", 128'({core_rst, boot_done, in_ready}), 128'(3'b010));
        in_valid = 1'b1;
        in_data  = 32'h0001_0000;
        repeat (5) tick();
        in_valid = 1'b0;
        chk_eq("run_ignores", 128'({in_ready, boot_done}), 128'(2'b01));
        wait_drain("load_drain");

        reload = 1'b1;
        tick();
        reload = 1'b0;
        chk_eq("reload_rst", 128'({core_rst, boot_done}), 128'(2'b10));
        push_clear();
        wait_drain("clear2_drain");

        // RF writes to r0 are dropped
        send(32'h8001_0000);
        send(32'hDEAD_BEEF);
        repeat (3) tick();

        // DMEM load with gaps, a no-op header, then a load ending exactly at depth
        send(32'h4003_0010);
        for (int i = 0; i < 3; i++) begin
            send(dmw[i]);
            push_wr(3'b010, 16'(16 + i), dmw[i]);
            tick();
        end
        send(32'h4000_0005);
        send(32'h4002_003E);
        send(32'hCAFE_0062);
        push_wr(3'b010, 16'd62, 32'hCAFE_0062);
        send(32'hCAFE_0063);
        push_wr(3'b010, 16'd63, 32'hCAFE_0063);
        wait_drain("dmem_drain");
        send(32'hC000_0000);
        chk_eq("run_entry2", 128'({core_rst, boot_done, in_ready}), 128'(3'b010));
        tick();
        reload = 1'b1;
        tick();
        reload = 1'b0;
        chk_eq("reload_rst2", 128'({core_rst, boot_done}), 128'(2'b10));
        push_clear();
        wait_drain("clear3_drain");

        // Out-of-range DMEM header
        send(32'h4004_003E);
        chk_eq("err_entry", 128'({err, in_ready, core_rst, boot_done}), 128'(4'b1010));
        in_valid = 1'b1;
        in_data  = 32'h1111_2222;
        repeat (8) tick();
        in_valid = 1'b0;
        reload   = 1'b1;
        tick();
        reload   = 1'b0;
        tick();
        chk_eq("err_hold", 128'({err, in_ready, core_rst, boot_done}), 128'(4'b1010));
        rst = 1'b0;
        #1;
        chk_reset_outs("err_cleared_by_rst");
        repeat (2) tick();
        rst = 1'b1;
        push_clear();
        wait_drain("clear4_drain");

        // Reset during a load abandons the in-flight write
        send(32'h0004_0010);
        send(32'h0BAD_0000);
        push_wr(3'b100, 16'h0010, 32'h0BAD_0000);
        send(32'h0BAD_0001);
        rst = 1'b0;
        #1;
        chk_reset_outs("mid_load_rst");
        repeat (3) tick();
        rst = 1'b1;
        push_clear();
        wait_drain("clear5_drain");
        chk_eq("restart_state", 128'({err, in_ready, core_rst}), 128'(3'b011));

        repeat (3) tick();
        chk_eq("queue_empty", 128'(exp_q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
